// File: rtl/fib_pkg.sv
// rtl/fib_pkg.sv - shared types and constants for the Fibonacci step sequencer
// Contents: FSM state enum, term reset values, default wrap limit,
//           8-bit binary to 3-digit BCD conversion (used when FIB_BCD_OUT_EN is defined).
package fib_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STEP_ADV = 2'd2
    } fib_state_t;

    localparam logic [7:0] TERM_RST  = 8'd1;
    localparam logic [7:0] PREV_RST  = 8'd0;
    localparam logic [7:0] LIMIT_DEF = 8'hDA;
    localparam logic [3:0] INDEX_RST = 4'd1;

    // Double-dabble: before each shift, any BCD digit >= 5 gets +3 so the
    // shift carries correctly into the next decimal digit.
    function automatic logic [11:0] bin_to_bcd(input logic [7:0] bin);
        logic [19:0] sh;
        sh = {12'd0, bin};
        for (int i = 0; i < 8; i++) begin
            if (sh[11:8]  >= 4'd5) sh[11:8]  = sh[11:8]  + 4'd3;
            if (sh[15:12] >= 4'd5) sh[15:12] = sh[15:12] + 4'd3;
            if (sh[19:16] >= 4'd5) sh[19:16] = sh[19:16] + 4'd3;
            sh = sh << 1;
        end
        return sh[19:8];
    endfunction

endpackage

// File: rtl/fib_tick_prescaler.sv
// rtl/fib_tick_prescaler.sv - free-running advance prescaler for RUN mode
// Ports: CLK_IN clock, RST_N async active-high reset, clear (sync, wins),
//        enable (count while high, hold while low), tick (strobe at count TICK_DIV-1).
module fib_tick_prescaler #(
    parameter int TICK_DIV = 12_000_000,
    parameter int CNT_W    = 24
) (
    input  logic CLK_IN,
    input  logic RST_N,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count;

    // Combinational so the advance lands on the same edge the count wraps.
    assign tick = enable && (count == CNT_LAST);

    always_ff @(posedge CLK_IN or posedge RST_N) begin
        if (RST_N) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            if (tick) count <= '0;
            else      count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/fib_step_sequencer.sv
// rtl/fib_step_sequencer.sv - Fibonacci term sequencer: free-run, single-step, clear
// Ports: CLK_IN clock, RST_N async active-high reset, RUN_EN free-run level,
//        STEP button level (rising edge = one advance), CLEAR sync return to index 1,
//        TERM current term, INDEX 1..12, TERM_VALID / WRAP one-cycle strobes,
//        BUSY high in RUN, BCD (only with FIB_BCD_OUT_EN) decimal digits of TERM.
module fib_step_sequencer
    import fib_pkg::*;
#(
    parameter int         TICK_DIV = 12_000_000,
    parameter int         CNT_W    = 24,
    parameter logic [7:0] LIMIT    = LIMIT_DEF
) (
    input  logic        CLK_IN,
    input  logic        RST_N,
    input  logic        RUN_EN,
    input  logic        STEP,
    input  logic        CLEAR,
    output logic [7:0]  TERM,
    output logic [3:0]  INDEX,
    output logic        TERM_VALID,
    output logic        WRAP,
    output logic        BUSY
`ifdef FIB_BCD_OUT_EN
    ,
    output logic [11:0] BCD
`endif
);

    fib_state_t state, state_next;
    logic [7:0] cur, cur_next;
    logic [7:0] prev, prev_next;
    logic [3:0] idx, idx_next;
    logic       tv_next, wrap_next;
    logic       step_d;
    logic       step_rise;
    logic       do_adv;
    logic       tick;
    logic [8:0] sum;

    assign step_rise = STEP && !step_d;
    assign sum       = {1'b0, cur} + {1'b0, prev};

    // Entering RUN restarts the count from zero; leaving RUN holds it.
    fib_tick_prescaler #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) u_prescaler (
        .CLK_IN (CLK_IN),
        .RST_N  (RST_N),
        .clear  (CLEAR || (state == IDLE && RUN_EN)),
        .enable (state == RUN && RUN_EN),
        .tick   (tick)
    );

    always_comb begin
        state_next = state;
        cur_next   = cur;
        prev_next  = prev;
        idx_next   = idx;
        tv_next    = 1'b0;
        wrap_next  = 1'b0;
        do_adv     = 1'b0;

        case (state)
            IDLE: begin
                if (RUN_EN)         state_next = RUN;
                else if (step_rise) state_next = STEP_ADV;
            end
            RUN: begin
                if (!RUN_EN)   state_next = IDLE;
                else if (tick) do_adv = 1'b1;
            end
            STEP_ADV: begin
                do_adv     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        if (do_adv) begin
            tv_next = 1'b1;
            if (sum >= {1'b0, LIMIT}) begin
                cur_next  = TERM_RST;
                prev_next = PREV_RST;
                idx_next  = INDEX_RST;
                wrap_next = 1'b1;
            end else begin
                prev_next = cur;
                cur_next  = sum[7:0];
                idx_next  = idx + 4'd1;
            end
        end

        // CLEAR overrides any advance in the same cycle.
        if (CLEAR) begin
            cur_next  = TERM_RST;
            prev_next = PREV_RST;
            idx_next  = INDEX_RST;
            tv_next   = 1'b1;
            wrap_next = 1'b0;
            if (state == STEP_ADV) state_next = IDLE;
        end
    end

    always_ff @(posedge CLK_IN or posedge RST_N) begin
        if (RST_N) begin
            state      <= IDLE;
            cur        <= TERM_RST;
            prev       <= PREV_RST;
            idx        <= INDEX_RST;
            TERM_VALID <= 1'b0;
            WRAP       <= 1'b0;
            BUSY       <= 1'b0;
            step_d     <= 1'b0;
        end else begin
            state      <= state_next;
            cur        <= cur_next;
            prev       <= prev_next;
            idx        <= idx_next;
            TERM_VALID <= tv_next;
            WRAP       <= wrap_next;
            BUSY       <= (state_next == RUN);
            step_d     <= STEP;
        end
    end

    assign TERM  = cur;
    assign INDEX = idx;

`ifdef FIB_BCD_OUT_EN
    always_ff @(posedge CLK_IN or posedge RST_N) begin
        if (RST_N) BCD <= 12'h001;
        else       BCD <= bin_to_bcd(cur_next);
    end
`endif

endmodule

// File: tb/tb_fib_step_sequencer.sv
// tb/tb_fib_step_sequencer.sv - directed self-checking bench for fib_step_sequencer
module tb_fib_step_sequencer;

    logic        clk_in = 1'b0;
    logic        rst    = 1'b0;
    logic        run_en = 1'b0;
    logic        step   = 1'b0;
    logic        clear  = 1'b0;
    logic [7:0]  term;
    logic [3:0]  index;
    logic        term_valid;
    logic        wrap;
    logic        busy;
`ifdef FIB_BCD_OUT_EN
    logic [11:0] bcd;
`endif

    int errors = 0;
    int checks = 0;
    int cur_idx;

    // Hand-written term for each index 1..12 (entry 0 unused).
    logic [7:0] idx_term [0:12];

    always #5 clk_in = ~clk_in;

    fib_step_sequencer #(
        .TICK_DIV (4),
        .CNT_W    (3)
    ) dut (
        .CLK_IN     (clk_in),
        .RST_N      (rst),
        .RUN_EN     (run_en),
        .STEP       (step),
        .CLEAR      (clear),
        .TERM       (term),
        .INDEX      (index),
        .TERM_VALID (term_valid),
        .WRAP       (wrap),
        .BUSY       (busy)
`ifdef FIB_BCD_OUT_EN
        ,
        .BCD        (bcd)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick_clk();
        @(posedge clk_in);
        #1;
    endtask

    // One RUN advance: three quiet cycles, then the advance on the fourth edge.
    task automatic run_adv(input int n);
        int nxt;
        for (int a = 0; a < n; a++) begin
            for (int q = 0; q < 3; q++) begin
                tick_clk();
                chk("run_quiet_tv", term_valid, 0);
            end
            tick_clk();
            nxt = (cur_idx == 12) ? 1 : cur_idx + 1;
            chk("run_tv", term_valid, 1);
            chk("run_term", term, idx_term[nxt]);
            chk("run_index", index, nxt);
            chk("run_wrap", wrap, (cur_idx == 12) ? 1 : 0);
            cur_idx = nxt;
        end
    endtask

    initial begin
        idx_term[0]  = 8'd0;
        idx_term[1]  = 8'd1;
        idx_term[2]  = 8'd1;
        idx_term[3]  = 8'd2;
        idx_term[4]  = 8'd3;
        idx_term[5]  = 8'd5;
        idx_term[6]  = 8'd8;
        idx_term[7]  = 8'd13;
        idx_term[8]  = 8'd21;
        idx_term[9]  = 8'd34;
        idx_term[10] = 8'd55;
        idx_term[11] = 8'd89;
        idx_term[12] = 8'd144;

        // Reset
        #2 rst = 1'b1;
        tick_clk();
        tick_clk();
        chk("rst_term", term, 1);
        chk("rst_index", index, 1);
        chk("rst_tv", term_valid, 0);
        chk("rst_wrap", wrap, 0);
        chk("rst_busy", busy, 0);
`ifdef FIB_BCD_OUT_EN
        chk("rst_bcd", bcd, 12'h001);
`endif
        rst = 1'b0;
        tick_clk();

        // Free run through a full sequence and the wrap
        run_en = 1'b1;
        tick_clk();
        chk("run_busy", busy, 1);
        chk("run_entry_tv", term_valid, 0);
        cur_idx = 1;
        run_adv(12);
        tick_clk();
        chk("wrap_one_cycle", wrap, 0);
        chk("tv_one_cycle", term_valid, 0);

        // Drop RUN_EN mid-count, re-enter: count restarts from 0
        tick_clk();
        run_en = 1'b0;
        tick_clk();
        chk("stop_busy", busy, 0);
        tick_clk();
        tick_clk();
        tick_clk();
        chk("stop_hold_term", term, 1);
        chk("stop_hold_index", index, 1);
        chk("stop_tv", term_valid, 0);
        run_en = 1'b1;
        tick_clk();
        chk("reenter_busy", busy, 1);
        run_adv(1);
        run_en = 1'b0;
        tick_clk();
        chk("idle_busy", busy, 0);

        // CLEAR in IDLE
        clear = 1'b1;
        tick_clk();
        chk("clr_idle_term", term, 1);
        chk("clr_idle_index", index, 1);
        chk("clr_idle_tv", term_valid, 1);
        chk("clr_idle_wrap", wrap, 0);
        clear = 1'b0;
        tick_clk();
        chk("clr_idle_tv_low", term_valid, 0);

        // STEP held high for 10 cycles: exactly one advance
        step = 1'b1;
        tick_clk();
        chk("step_n_tv", term_valid, 0);
        chk("step_n_index", index, 1);
        tick_clk();
        chk("step_n1_tv", term_valid, 1);
        chk("step_n1_term", term, 1);
        chk("step_n1_index", index, 2);
        for (int c = 0; c < 8; c++) begin
            tick_clk();
            chk("step_hold_tv", term_valid, 0);
        end
        chk("step_hold_index", index, 2);
        step = 1'b0;
        tick_clk();

        // Step to INDEX 7, then CLEAR
        for (int p = 0; p < 5; p++) begin
            step = 1'b1;
            tick_clk();
            step = 1'b0;
            tick_clk();
            tick_clk();
        end
        chk("walk_term", term, 13);
        chk("walk_index", index, 7);
        clear = 1'b1;
        tick_clk();
        chk("clr7_term", term, 1);
        chk("clr7_index", index, 1);
        chk("clr7_tv", term_valid, 1);
        chk("clr7_wrap", wrap, 0);
        clear = 1'b0;

        // CLEAR coincident with the RUN tick at TERM=89
        run_en = 1'b1;
        tick_clk();
        cur_idx = 1;
        run_adv(10);
        chk("pre_tie_term", term, 89);
        tick_clk();
        tick_clk();
        tick_clk();
        clear = 1'b1;
        tick_clk();
        chk("tie_term", term, 1);
        chk("tie_index", index, 1);
        chk("tie_tv", term_valid, 1);
        chk("tie_wrap", wrap, 0);
        clear = 1'b0;
        cur_idx = 1;

        // Asynchronous reset mid-RUN at TERM=55
        run_adv(9);
        chk("pre_rst_term", term, 55);
        tick_clk();
        #2 rst = 1'b1;
        #1;
        chk("arst_term", term, 1);
        chk("arst_index", index, 1);
        chk("arst_busy", busy, 0);
        chk("arst_tv", term_valid, 0);
`ifdef FIB_BCD_OUT_EN
        chk("arst_bcd", bcd, 12'h001);
`endif
        tick_clk();
        run_en = 1'b0;
        rst = 1'b0;
        tick_clk();
        chk("post_rst_busy", busy, 0);
        chk("post_rst_term", term, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fib_step_sequencer.md
# fib_step_sequencer

Sequencing controller for the 8-bit Fibonacci datapath that drives the Tang Primer seven-segment display. It owns the two term registers and decides when the sequence advances: free-running at a prescaled rate, single-stepped from a push-button, or cleared back to the first term. Outputs are the current term, its index and one-cycle strobes. The display driver consumes these outputs.

## Interface
- TICK_DIV, 12_000_000: clock cycles per advance in RUN (0.5 s at 24 MHz); minimum 2
- CNT_W, 24: prescaler counter width; must satisfy 2^CNT_W ≥ TICK_DIV
- LIMIT, 8'hDA: the sequence wraps when the next sum is ≥ LIMIT
- CLK_IN  in  1  system clock; all logic on the rising edge
- RST_N  in  1  asynchronous, active-high reset
- RUN_EN  in  1  level; high = free-run, low = stop after the current cycle
- STEP  in  1  button level, synchronous; its rising edge requests one advance
- CLEAR  in  1  synchronous; high for one or more cycles returns the sequence to index 1
- TERM  out  8  current Fibonacci term
- INDEX  out  4  current term index, 1..12
- TERM_VALID  out  1  one-cycle strobe; TERM/INDEX changed at the preceding edge
- WRAP  out  1  one-cycle strobe; an advance wrapped to index 1
- BUSY  out  1  high while in RUN

## Operation
- Internal state: cur (= TERM), prev, INDEX, FSM state, prescaler count, STEP delayed copy.
- Reset: cur=1, prev=0, INDEX=1, state IDLE, count=0, TERM_VALID=0, WRAP=0, BUSY=0, STEP delayed copy=0.
- Advance operation: the next sum is computed 9 bits wide as cur+prev.
  - If sum ≥ LIMIT: cur=1, prev=0, INDEX=1, WRAP=1.
  - Otherwise: prev=cur, cur=sum[7:0], INDEX+1.
- With the default LIMIT the sequence is 1,1,2,3,5,8,13,21,34,55,89,144. The term 233 is never shown; the sequence wraps to 1.
- FSM states:
  - IDLE: if RUN_EN=1, go to RUN and set count=0. Else if a STEP rising edge is seen, go to STEP_ADV.
  - RUN: count increments each cycle. When count==TICK_DIV-1, perform the advance and set count=0. If RUN_EN=0, go to IDLE and hold count.
  - STEP_ADV: perform the advance and go to IDLE. This state lasts exactly one cycle.
- STEP rising edges are ignored in RUN and STEP_ADV. Holding STEP high produces exactly one advance.
- CLEAR has the highest priority in every state:
  - cur=1, prev=0, INDEX=1, count=0.
  - TERM_VALID=1, WRAP=0.
  - The state is unchanged, except that STEP_ADV goes to IDLE.
- CLEAR in the same cycle as a tick or STEP_ADV: CLEAR wins and no advance occurs.
- BUSY = (state==RUN), registered.

## Timing
- RUN: the first advance occurs TICK_DIV cycles after the RUN_EN=1 sample. Later advances occur every TICK_DIV cycles.
- STEP: the rising edge is sampled at edge N (IDLE→STEP_ADV). TERM/INDEX update at edge N+1. TERM_VALID is high in cycle N+1..N+2.
- TERM_VALID and WRAP are registered and high for exactly one cycle. WRAP coincides with the TERM_VALID of the wrapping advance.
- An asynchronous reset mid-RUN immediately restores all reset values. After release, operation resumes from IDLE.

## Configuration
- FIB_BCD_OUT_EN defined:
  - Adds output BCD, 12 bits: hundreds/tens/units of TERM, produced by double-dabble.
  - BCD is registered alongside TERM, with no extra latency.
  - Reset value 12'h001.
- FIB_BCD_OUT_EN not defined: the BCD port and its logic are absent. All other behaviour is identical.

## Structure
- fib_pkg: FSM state enum (IDLE, RUN, STEP_ADV), TERM_RST=8'd1, PREV_RST=8'd0, LIMIT_DEF=8'hDA.
- One sub-module, fib_tick_prescaler: takes clear and enable, and outputs the tick strobe at count TICK_DIV-1.

## Test plan
- Reset, then TICK_DIV=4, RUN_EN=1 held: TERM_VALID pulses every 4 cycles. TERM goes 1,1,2,…,144, then 1 with WRAP=1 and INDEX=1.
- RUN_EN=0, STEP high for 10 cycles: exactly one advance occurs, TERM 1→1 and INDEX 1→2, with TERM_VALID 2 cycles after the STEP edge.
- From INDEX=7 (TERM=13), pulse CLEAR: at the next edge TERM=1, INDEX=1, TERM_VALID=1, WRAP=0.
- CLEAR asserted in the same cycle as a RUN tick at TERM=89: the result is TERM=1, INDEX=1, not 144.
- RUN_EN dropped mid-count, then raised again: BUSY falls, TERM is held, and the count restarts from 0. The next advance comes 4 cycles after the re-entry.
- Assert RST_N asynchronously mid-RUN at TERM=55: the outputs immediately show TERM=1, INDEX=1, BUSY=0 (and BCD=12'h001 with FIB_BCD_OUT_EN).
